// File: rtl/riscv_mem_responder_if.sv
// ---------------------------------------------------------------------------
// riscv_mem_responder_if
// Bundles the hart fetch/data ports and the byte-stream loader port of
// riscv_mem_responder.
//   pc / instruction                    : fetch port (byte address -> word)
//   mem_addr / mem_data / mem_write     : data port, store side
//   mem_read                            : data port, load side
//   load_valid / load_ready / load_byte
//   / load_last                         : loader byte stream (valid/ready)
//   core_rst / load_done / load_count   : loader status and hart reset
//   tohost_data / tohost_valid          : tohost mailbox, only with MEM_MMIO_EN
// Modports: master = hart + loader side, slave = memory responder.
// ---------------------------------------------------------------------------
interface riscv_mem_responder_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
);
  logic [XLEN-1:0]          pc;
  logic [31:0]              instruction;
  logic [XLEN-1:0]          mem_addr;
  logic [XLEN-1:0]          mem_data;
  logic                     mem_write;
  logic [XLEN-1:0]          mem_read;
  logic                     load_valid;
  logic                     load_ready;
  logic [7:0]               load_byte;
  logic                     load_last;
  logic                     core_rst;
  logic                     load_done;
  logic [$clog2(DEPTH):0]   load_count;
`ifdef MEM_MMIO_EN
  logic [XLEN-1:0]          tohost_data;
  logic                     tohost_valid;
`endif

  modport slave (
    input  pc, mem_addr, mem_data, mem_write, load_valid, load_byte, load_last,
    output instruction, mem_read, load_ready, core_rst, load_done, load_count
`ifdef MEM_MMIO_EN
    , output tohost_data, output tohost_valid
`endif
  );

  modport master (
    output pc, mem_addr, mem_data, mem_write, load_valid, load_byte, load_last,
    input  instruction, mem_read, load_ready, core_rst, load_done, load_count
`ifdef MEM_MMIO_EN
    , input tohost_data, input tohost_valid
`endif
  );
endinterface

// File: rtl/riscv_mem_responder.sv
// ---------------------------------------------------------------------------
// riscv_mem_responder
// Word memory behind a hart's fetch and data ports. After reset a byte-stream
// loader fills the array (little-endian, 4 bytes per word) while the hart is
// held in reset; the final byte moves the block to RUN, releasing core_rst.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : riscv_mem_responder_if.slave (fetch, data, loader, status)
// Reads are combinational on both ports; writes (loader or hart store) are
// synchronous. Array contents are never reset.
// Optional feature macro MEM_MMIO_EN: a RUN-mode store to 0xFFFF_FFF0 goes
// to the tohost_data register with a one-cycle tohost_valid pulse instead of
// the array, and data reads of that address return 0.
// ---------------------------------------------------------------------------
module riscv_mem_responder #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 1024,
  parameter int LOAD_BASE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  riscv_mem_responder_if.slave     bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] BASE_IDX  = AW'(LOAD_BASE / 4);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       buf_r;        // lanes 0..2 of the word being assembled
  logic [AW-1:0]     wr_idx_r;
  logic [CW-1:0]     load_count_r;
  logic              core_rst_r;
  logic              load_ready_r;
  logic              load_done_r;

  logic [XLEN-1:0]   mem_r [DEPTH];

  logic [AW-1:0]     fetch_idx_s;
  logic [AW-1:0]     data_idx_s;
  logic              load_fire_s;
  logic              load_wr_s;
  logic [XLEN-1:0]   load_word_s;
  logic              mmio_hit_s;
  logic              run_wr_s;
  logic              unused_addr_s;

  // Byte offset and out-of-range address bits do not select a word.
  assign fetch_idx_s   = bus.pc[AW+1:2];
  assign data_idx_s    = bus.mem_addr[AW+1:2];
  assign unused_addr_s = ^{bus.pc[XLEN-1:AW+2], bus.pc[1:0],
                           bus.mem_addr[XLEN-1:AW+2], bus.mem_addr[1:0]};

`ifdef MEM_MMIO_EN
  localparam logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'hFFFF_FFF0);
  assign mmio_hit_s = (bus.mem_addr == TOHOST_ADDR);
`else
  assign mmio_hit_s = 1'b0;
`endif

  assign load_fire_s = (state_r == LOAD) && load_ready_r && bus.load_valid;
  assign load_wr_s   = load_fire_s && ((byte_cnt_r == 2'd3) || bus.load_last);
  assign run_wr_s    = (state_r == RUN) && bus.mem_write && !mmio_hit_s;

  // Merge the incoming byte into its lane; lanes above it stay zero.
  always_comb begin
    load_word_s = '0;
    case (byte_cnt_r)
      2'd0:    load_word_s[31:0] = {24'h00_0000, bus.load_byte};
      2'd1:    load_word_s[31:0] = {16'h0000, bus.load_byte, buf_r[7:0]};
      2'd2:    load_word_s[31:0] = {8'h00, bus.load_byte, buf_r[15:0]};
      2'd3:    load_word_s[31:0] = {bus.load_byte, buf_r[23:0]};
      default: load_word_s       = '0;
    endcase
  end

  // Zero-latency reads; new contents appear the cycle after the write edge.
  assign bus.instruction = mem_r[fetch_idx_s][31:0];
  assign bus.mem_read    = mmio_hit_s ? '0 : mem_r[data_idx_s];

  // Array write port, shared by the loader (LOAD) and hart stores (RUN).
  always_ff @(posedge clk) begin
    if (load_wr_s) begin
      mem_r[wr_idx_r] <= load_word_s;
    end else if (run_wr_s) begin
      mem_r[data_idx_s] <= bus.mem_data;
    end
  end

  // Loader FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= LOAD;
      byte_cnt_r   <= 2'd0;
      buf_r        <= 24'h00_0000;
      wr_idx_r     <= BASE_IDX;
      load_count_r <= '0;
      core_rst_r   <= 1'b1;
      load_ready_r <= 1'b1;
      load_done_r  <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (load_fire_s) begin
            if (load_wr_s) begin
              byte_cnt_r <= 2'd0;
              buf_r      <= 24'h00_0000;
              wr_idx_r   <= wr_idx_r + AW'(1);
              if (load_count_r != COUNT_MAX) begin
                load_count_r <= load_count_r + CW'(1);
              end
            end else begin
              buf_r      <= buf_r | (24'(bus.load_byte) << {byte_cnt_r, 3'b000});
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
            if (bus.load_last) begin
              state_r      <= RUN;
              load_ready_r <= 1'b0;
              core_rst_r   <= 1'b0;
              load_done_r  <= 1'b1;
            end
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

  assign bus.core_rst   = core_rst_r;
  assign bus.load_ready = load_ready_r;
  assign bus.load_done  = load_done_r;
  assign bus.load_count = load_count_r;

`ifdef MEM_MMIO_EN
  logic [XLEN-1:0] tohost_data_r;
  logic            tohost_valid_r;
  logic            tohost_wr_s;

  assign tohost_wr_s = (state_r == RUN) && bus.mem_write && mmio_hit_s;

  // tohost mailbox: capture store data, pulse valid for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tohost_data_r  <= '0;
      tohost_valid_r <= 1'b0;
    end else begin
      tohost_valid_r <= tohost_wr_s;
      if (tohost_wr_s) begin
        tohost_data_r <= bus.mem_data;
      end
    end
  end

  assign bus.tohost_data  = tohost_data_r;
  assign bus.tohost_valid = tohost_valid_r;
`endif
endmodule

// File: doc/riscv_mem_responder.md
Name: riscv_mem_responder

Overview:
- Memory responder that sits on the far side of the hart's fetch port (`pc` → `instruction`) and data port (`mem_addr`/`mem_data`/`mem_write` → `mem_read`).
- Single word array with two combinational read ports and one synchronous write port.
- A byte-stream loader FSM fills the array after reset.
- The block holds the hart in reset (`core_rst`) until loading completes.

Parameters:
- XLEN, 32, data and address width.
- DEPTH, 1024, number of XLEN-bit words; must be a power of two.
- LOAD_BASE, 0, byte address where the loader writes its first word; must be word aligned.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc  in  XLEN  fetch byte address from the hart
- instruction  out  32  word at `pc`
- mem_addr  in  XLEN  data byte address
- mem_data  in  XLEN  store data
- mem_write  in  1  store strobe
- mem_read  out  XLEN  word at `mem_addr`
- load_valid  in  1  loader byte valid
- load_ready  out  1  loader byte accepted when high together with `load_valid`
- load_byte  in  8  loader byte
- load_last  in  1  marks the final byte of the image
- core_rst  out  1  hart reset, active-high
- load_done  out  1  image loaded, array in run mode
- load_count  out  $clog2(DEPTH)+1  number of words written by the loader

Behaviour:
- Indexing: word index = `addr[$clog2(DEPTH)+1:2]`. `addr[1:0]` is ignored. Higher bits are ignored, so addresses wrap modulo DEPTH*4.
- Reads: `instruction` and `mem_read` are purely combinational from the array (zero latency).
  - A read in the same cycle as a write to the same word returns the old content.
  - The new content is visible from the cycle after the write edge.
- Array contents are not reset. Reset never clears or modifies stored words.
- FSM states: LOAD, RUN.
- Reset (asynchronous): state=LOAD, `core_rst`=1, `load_ready`=1, `load_done`=0, `load_count`=0, byte lane=0, word buffer=0, write index=LOAD_BASE/4.
- LOAD state:
  - An accepted byte (`load_valid` & `load_ready`) goes into lane `byte_cnt`, little-endian: lane 0 is bits [7:0].
  - The word is written when lane==3 or `load_last`=1. It is written at the same edge the byte is accepted, combining the buffer with the incoming byte.
  - Unfilled upper lanes of a partial word are written as zero.
  - After each word write: write index increments (wraps modulo DEPTH), `load_count` increments (saturates at DEPTH), lane and buffer clear.
  - Hart-side `mem_write` is ignored in LOAD.
- LOAD→RUN: at the edge that accepts a byte with `load_last`=1. From the next cycle: `load_ready`=0, `core_rst`=0, `load_done`=1. All three are registered outputs.
- RUN state:
  - `mem_write`=1 writes `mem_data` to the indexed word at the posedge.
  - `load_valid` is ignored; `load_ready` stays 0.
  - RUN is left only via `rst`.
- `load_last` with `load_valid`=0 has no effect. Bytes are never lost under `load_valid` toggling.
- Reset mid-load: FSM returns to LOAD and all counters clear. The partial word buffer is discarded. Words already written stay in the array.

Optional Feature:
- Macro: `MEM_MMIO_EN`.
- Enabled:
  - Adds ports `tohost_data` (out, XLEN) and `tohost_valid` (out, 1), both reset to 0.
  - In RUN, a `mem_write` to exactly `mem_addr`=XLEN'hFFFF_FFF0 does not touch the array. Instead `tohost_data <= mem_data` and `tohost_valid` pulses high for exactly one cycle after the edge.
  - A read at that address returns 0.
- Disabled: the ports are absent, and that address aliases into the array by normal index wrap.

Test Plan:
1. Reset, then stream bytes 13 00 00 00 93 00 10 00 with `load_last` on the 8th → mem[0]=0x00000013, mem[1]=0x00100093, `load_count`=2; `core_rst` falls and `load_done` rises the cycle after the last byte; `pc`=4 gives `instruction`=0x00100093.
2. Stream 5 bytes 01 02 03 04 EE with `load_last` on the 5th, with `load_valid` deasserted for 3 idle cycles mid-stream → mem[0]=0x04030201, mem[1]=0x000000EE, `load_count`=2.
3. RUN, `mem_write`=1, `mem_addr`=0x100, `mem_data`=0xDEADBEEF → `mem_read` shows the old value in the same cycle and 0xDEADBEEF the next cycle with `mem_addr`=0x100; with `mem_addr`=0x102, the same word is returned.
4. DEPTH=1024: store 0x12345678 at 0x1000 → read at 0x0 returns 0x12345678; `load_valid` pulses in RUN leave `load_ready`=0 and the array unchanged.
5. After 6 accepted bytes, assert `rst` for 1 cycle → `core_rst`=1, `load_count`=0, mem[0] retained. The next 4 bytes AA BB CC DD with `load_last` → mem[0]=0xDDCCBBAA.
6. With `MEM_MMIO_EN`: RUN store of 0x41 to 0xFFFFFFF0 → `tohost_data`=0x41 with `tohost_valid` high for exactly 1 cycle; array word at index 1020 unchanged; read at 0xFFFFFFF0 returns 0.
